dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the CPU load/store request interface.
//  - Accepts one word-addressed request at a time over a valid/ready request channel.
//  - Applies a programmable number of wait states.
//  - Commits byte-strobed writes, or reads a word, then returns a response over a
//    valid/ready response channel.
//  - Sits between the core's memory stage and on-chip SRAM; used to exercise stall paths.
// PARAMETERS
//  DEPTH_WORDS  1024           storage size in 32-bit words (power of 2)
//  WAIT_CYCLES  2              extra cycles between accept and rsp_valid (0..15)
//  BASE_ADDR    32'h8000_0000  byte address of word 0
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_wen     in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, lane-aligned
//  req_wstrb   in   4   byte enables for a store; ignored for a load
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   initiator takes the response
//  rsp_rdata   out  32  load data (full word); 0 for a store
//  rsp_err     out  1   access error (driven only with ACCESS_CHECK_EN)
// BEHAVIOUR
//  Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    wait counter=0. Memory array contents are not reset.
//  FSM IDLE -> WAIT -> RESP -> IDLE. At most one request is outstanding.
//  IDLE: a handshake (req_valid & req_ready) latches addr, wdata, wstrb and wen.
//    - WAIT_CYCLES==0: go to EXEC point immediately, i.e. RESP on the next edge.
//    - Otherwise: enter WAIT with the counter loaded to WAIT_CYCLES-1.
//  WAIT: the counter decrements each cycle; at 0, the EXEC point occurs and the
//    FSM moves to RESP.
//  EXEC point, on the clock edge entering RESP:
//    - Store: memory bytes with wstrb[i]=1 are written; rsp_rdata <= 0.
//    - Load: rsp_rdata <= mem[index] (the old word; no write occurs on a load).
//  Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
//  RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1.
//    The handshake edge returns the FSM to IDLE and clears rsp_valid.
//    req_ready rises in the cycle after the response handshake (no same-cycle reissue).
//  Word index is (req_addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
//    The subtraction is modulo 2^32.
//  A store with wstrb=4'b0000 completes normally and modifies nothing.
//  While in IDLE, req_* values that are not accepted have no effect.
//  Reset mid-operation (WAIT or RESP):
//    - FSM returns to IDLE and rsp_valid drops immediately (asynchronous).
//    - A store not yet at its EXEC point is discarded.
//    - A store already committed remains in memory.
// CONFIGURATION
//  ACCESS_CHECK_EN defined:
//    - Error when the address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
//    - Error when req_addr[1:0]!=0 on a load.
//    - Error when a store's wstrb is not one of: 0000, 0001, 0010, 0100, 1000,
//      0011, 1100, 1111.
//    - On error: no write, rsp_rdata=0, rsp_err=1 for that response. The latency
//      is unchanged.
//  ACCESS_CHECK_EN undefined:
//    - No checks; the address wraps modulo DEPTH_WORDS and req_addr[1:0] is ignored.
//    - rsp_err is tied to 0.
// TESTING
//  1. Reset, then store 0xDEADBEEF to 0x8000_0010 with wstrb=1111 and rsp_ready=1:
//     rsp_valid at accept+3 cycles with WAIT_CYCLES=2; rsp_rdata=0.
//  2. Load 0x8000_0010 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3. Store 0x0000_AB00 to 0x8000_0010 with wstrb=0010, then load it -> 0xDEADABEF.
//  4. Hold rsp_ready=0 for 5 cycles during a load:
//     - rsp_valid and rsp_rdata stay stable and req_ready stays 0.
//     - Release rsp_ready -> req_ready=1 in the next cycle.
//  5. Assert rst in the WAIT cycle of a store to 0x8000_0020:
//     - rsp_valid never rises.
//     - A later load of 0x8000_0020 returns the pre-store value.
//  6. With ACCESS_CHECK_EN: load 0x7FFF_FFFC -> rsp_err=1, rsp_rdata=0.
//     Store with wstrb=0110 -> rsp_err=1, and memory is unchanged.
//     Without the macro, the same load wraps to index DEPTH_WORDS-1 with rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with programmable wait states; optional ACCESS_CHECK_EN enables error checks
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic [IW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wen, err, err_c, acc, exec, unused_off;
    logic [31:0]   off;
    logic [31:0]   mem [DEPTH_WORDS];

    assign off        = req_addr - BASE_ADDR;
    assign acc        = req_valid & req_ready;
    assign exec       = (state == S_WAIT) && (cnt == 4'd0);
    assign unused_off = &{1'b0, off[1:0], off[31:IW+2]};

`ifdef ACCESS_CHECK_EN
    assign err_c = (off[31:IW+2] != '0)
                 | (~req_wen & (req_addr[1:0] != 2'b00))
                 | (req_wen & !(req_wstrb inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                                  4'b1000, 4'b0011, 4'b1100, 4'b1111}));
`else
    assign err_c = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next state: WAIT always spans WAIT_CYCLES+1 cycles so rsp_valid lands at accept+WAIT_CYCLES+1
    always_comb begin
        state_nx = state == S_IDLE ? (req_valid ? S_WAIT : S_IDLE)
                 : state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT)
                 : (rsp_ready ? S_IDLE : S_RESP);
    end

    // handshake outputs decoded from state
    always_comb begin
        req_ready = state == S_IDLE;
        rsp_valid = state == S_RESP;
    end

    // request capture, wait counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            idx       <= '0;
            wdata     <= 32'd0;
            wstrb     <= 4'd0;
            wen       <= 1'b0;
            err       <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (acc) begin
                cnt   <= 4'(WAIT_CYCLES);
                idx   <= off[IW+1:2];
                wdata <= req_wdata;
                wstrb <= req_wstrb;
                wen   <= req_wen;
                err   <= err_c;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec) begin
                rsp_rdata <= (wen | err) ? 32'd0 : mem[idx];
                rsp_err   <= err;
            end
        end
    end

    // byte-strobed commit at the exec point; a reset before this edge leaves memory untouched
    always_ff @(posedge clk) begin
        if (exec && wen && !err)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    dmem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one request and return cycles from accept edge to rsp_valid
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int l);
        @(negedge clk);
        req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        l = 0;
        while (!rsp_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        if (l >= 40) check("rsp_timeout", 32'(l), 32'd0);
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r, output logic e, output int l);
        issue(w, a, d, s, l);
        r = rsp_rdata;
        e = rsp_err;
        @(posedge clk); #1;
        check("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_rdata", rd, 32'd0);
        check("t1_err", {31'd0, er}, 32'd0);

        xact(1'b0, 32'h8000_0010, 32'd0, 4'b0000, rd, er, lat);
        check("t2_latency", 32'(lat), 32'd3);
        check("t2_rdata", rd, 32'hDEAD_BEEF);
        check("t2_err", {31'd0, er}, 32'd0);

        xact(1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, rd, er, lat);
        xact(1'b0, 32'h8000_0010, 32'd0, 4'b1111, rd, er, lat);
        check("t3_byte_lane", rd, 32'hDEAD_ABEF);

        xact(1'b1, 32'h8000_0010, 32'h1111_1111, 4'b0000, rd, er, lat);
        check("zero_strb_rdata", rd, 32'd0);
        xact(1'b1, 32'h8000_0014, 32'h1234_5678, 4'b1111, rd, er, lat);
        xact(1'b0, 32'h8000_0010, 32'd0, 4'b0000, rd, er, lat);
        check("zero_strb_unchanged", rd, 32'hDEAD_ABEF);
        xact(1'b0, 32'h8000_0014, 32'd0, 4'b0000, rd, er, lat);
        check("neighbour_word", rd, 32'h1234_5678);

        rsp_ready = 1'b0;
        issue(1'b0, 32'h8000_0010, 32'd0, 4'b0000, lat);
        check("t4_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("t4_hold_rdata", rsp_rdata, 32'hDEAD_ABEF);
            check("t4_hold_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("t4_ready_rise", {31'd0, req_ready}, 32'd1);

        xact(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'b1111, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
        req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_in_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("t5_async_ready", {31'd0, req_ready}, 32'd1);
        check("t5_async_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t5_no_valid", {31'd0, rsp_valid}, 32'd0);
        end
        xact(1'b0, 32'h8000_0020, 32'd0, 4'b0000, rd, er, lat);
        check("t5_prestore", rd, 32'h0BAD_F00D);

`ifdef ACCESS_CHECK_EN
        xact(1'b0, 32'h7FFF_FFFC, 32'd0, 4'b0000, rd, er, lat);
        check("t6_oob_err", {31'd0, er}, 32'd1);
        check("t6_oob_rdata", rd, 32'd0);
        check("t6_oob_latency", 32'(lat), 32'd3);
        xact(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0110, rd, er, lat);
        check("t6_strb_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h8000_0012, 32'd0, 4'b0000, rd, er, lat);
        check("t6_misalign_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h8000_0010, 32'd0, 4'b0000, rd, er, lat);
        check("t6_mem_unchanged", rd, 32'hDEAD_ABEF);
        check("t6_ok_err", {31'd0, er}, 32'd0);
`else
        xact(1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'b1111, rd, er, lat);
        xact(1'b0, 32'h7FFF_FFFC, 32'd0, 4'b0000, rd, er, lat);
        check("t6_wrap_rdata", rd, 32'hCAFE_F00D);
        check("t6_wrap_err", {31'd0, er}, 32'd0);
        xact(1'b0, 32'h8000_0012, 32'd0, 4'b0000, rd, er, lat);
        check("t6_low_bits_ignored", rd, 32'hDEAD_ABEF);
        xact(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0110, rd, er, lat);
        xact(1'b0, 32'h8000_0010, 32'd0, 4'b0000, rd, er, lat);
        check("t6_strb0110_write", rd, 32'hDEFF_FFEF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
